// File: rtl/quad_pkg.sv
// Shared types and Gray-code helpers for the quadrature step decoder.
// Used by quad_chan_filter and quad_step_decoder.
package quad_pkg;

    typedef enum logic [0:0] {
        S_PRIME = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    localparam logic [1:0] QA_00 = 2'b00;
    localparam logic [1:0] QA_01 = 2'b01;
    localparam logic [1:0] QA_11 = 2'b11;
    localparam logic [1:0] QA_10 = 2'b10;

    // Wide enough for the largest stability count of 15.
    localparam int CNT_W = 4;

    function automatic logic is_fwd(input logic [1:0] prev, input logic [1:0] next);
        logic fwd;
        fwd = 1'b0;
        case (prev)
            QA_00:   fwd = (next == QA_01);
            QA_01:   fwd = (next == QA_11);
            QA_11:   fwd = (next == QA_10);
            QA_10:   fwd = (next == QA_00);
            default: fwd = 1'b0;
        endcase
        return fwd;
    endfunction

    function automatic logic is_illegal(input logic [1:0] prev, input logic [1:0] next);
        return (prev ^ next) == 2'b11;
    endfunction

endpackage

// File: rtl/quad_chan_filter.sv
// One encoder channel: multi-flop synchronizer followed by a stability counter
// that only lets the filtered level change after FILT_LEN differing samples.
module quad_chan_filter
    import quad_pkg::*;
#(
    parameter int FILT_LEN    = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic raw_in,
    output logic filt_out
);

    localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(FILT_LEN);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   filt_reg;
    logic                   sync_bit;
    logic                   sync_next;

    assign sync_bit  = sync_reg[SYNC_STAGES-1];
    assign sync_next = sync_reg[SYNC_STAGES-2];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '0;
            cnt_reg  <= '0;
            filt_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_in};
            if (!enable) begin
                filt_reg <= sync_next;
                cnt_reg  <= '0;
            end else if (cnt_reg == FILT_MAX) begin
                filt_reg <= ~filt_reg;
                cnt_reg  <= '0;
            end else if (sync_bit != filt_reg) begin
                cnt_reg <= cnt_reg + 1'b1;
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    // While priming, expose the level the synchronizer output takes at this
    // edge so the decoder's snapshot matches what the filter starts from.
    assign filt_out = enable ? filt_reg : sync_next;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: filtered channels, Gray-step decode, sticky error.
// Define QUAD_INDEX_EN to add the Z channel (z_in) and the index pulse output.
module quad_step_decoder
    import quad_pkg::*;
#(
    parameter int FILT_LEN    = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_in,
    input  logic       b_in,
    input  logic       err_clr,
    output logic       step,
    output logic       count_up_down,
    output logic       err,
    output logic       err_flag,
    output logic [1:0] state_ab
`ifdef QUAD_INDEX_EN
    ,
    input  logic       z_in,
    output logic       index
`endif
);

    localparam logic [1:0] PRIME_LAST = 2'(SYNC_STAGES - 1);
`ifdef QUAD_INDEX_EN
    localparam int NCH = 3;
`else
    localparam int NCH = 2;
`endif

    logic [NCH-1:0] raw_vec;
    logic [NCH-1:0] filt_vec;
    state_t         state_reg;
    logic [1:0]     prime_cnt_reg;
    logic [1:0]     state_ab_reg;
    logic           step_reg;
    logic           err_reg;
    logic           dir_reg;
    logic           err_flag_reg;
    logic           run;
    logic [1:0]     cur_ab;
    logic           ab_changed;
    logic           illegal;
    logic           z_err;
    logic           err_set;

`ifdef QUAD_INDEX_EN
    assign raw_vec = {z_in, a_in, b_in};
`else
    assign raw_vec = {a_in, b_in};
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            quad_chan_filter #(
                .FILT_LEN   (FILT_LEN),
                .SYNC_STAGES(SYNC_STAGES)
            ) u_filt (
                .clk     (clk),
                .reset   (reset),
                .enable  (run),
                .raw_in  (raw_vec[gi]),
                .filt_out(filt_vec[gi])
            );
        end
    endgenerate

    assign run        = (state_reg == S_RUN);
    assign cur_ab     = filt_vec[1:0];
    assign ab_changed = run && (cur_ab != state_ab_reg);
    assign illegal    = ab_changed && is_illegal(state_ab_reg, cur_ab);
    // The visible err pulse also counts as a set so a coincident clear loses.
    assign err_set    = illegal | err_reg | z_err;

`ifdef QUAD_INDEX_EN
    logic z_prev_reg;
    logic index_reg;
    logic z_rise;
    logic index_hit;

    assign z_rise    = run && filt_vec[2] && !z_prev_reg;
    assign index_hit = z_rise && (state_ab_reg == QA_00);
    assign z_err     = z_rise && !index_hit;
    assign index     = index_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            z_prev_reg <= 1'b0;
            index_reg  <= 1'b0;
        end else begin
            z_prev_reg <= filt_vec[2];
            index_reg  <= index_hit;
        end
    end
`else
    assign z_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_PRIME;
            prime_cnt_reg <= 2'd0;
            state_ab_reg  <= QA_00;
            step_reg      <= 1'b0;
            err_reg       <= 1'b0;
            dir_reg       <= 1'b1;
            err_flag_reg  <= 1'b0;
        end else begin
            step_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                S_PRIME: begin
                    if (prime_cnt_reg == PRIME_LAST) begin
                        state_reg    <= S_RUN;
                        state_ab_reg <= cur_ab;
                    end else begin
                        prime_cnt_reg <= prime_cnt_reg + 2'd1;
                    end
                end
                S_RUN: begin
                    if (ab_changed) begin
                        state_ab_reg <= cur_ab;
                        if (illegal) begin
                            err_reg <= 1'b1;
                        end else begin
                            step_reg <= 1'b1;
                            dir_reg  <= is_fwd(state_ab_reg, cur_ab);
                        end
                    end
                end
                default: state_reg <= S_PRIME;
            endcase
            if (err_set) begin
                err_flag_reg <= 1'b1;
            end else if (err_clr) begin
                err_flag_reg <= 1'b0;
            end
        end
    end

    assign step          = step_reg;
    assign err           = err_reg;
    assign count_up_down = dir_reg;
    assign err_flag      = err_flag_reg;
    assign state_ab      = state_ab_reg;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder: directed A/B vectors push expected
// step/err events; a negedge monitor pops and compares each pulse it sees.
module tb_quad_step_decoder;

    typedef struct {
        logic       kind;   // 0 = step, 1 = err
        logic       dir;
        logic [1:0] ab;
        int         due;
    } ev_t;

    // Clean edge to visible pulse: SYNC_STAGES + FILT_LEN + 1 edges, plus the
    // edge that first samples an input driven on a negedge.
    localparam int LAT = 7;

    logic       clk;
    logic       reset;
    logic       a_in;
    logic       b_in;
    logic       err_clr;
    logic       step;
    logic       count_up_down;
    logic       err;
    logic       err_flag;
    logic [1:0] state_ab;
`ifdef QUAD_INDEX_EN
    logic       index_w;
`endif

    int  cyc;
    int  checks;
    int  errors;
    ev_t sb_q[$];

    quad_step_decoder dut (
        .clk          (clk),
        .reset        (reset),
        .a_in         (a_in),
        .b_in         (b_in),
        .err_clr      (err_clr),
        .step         (step),
        .count_up_down(count_up_down),
        .err          (err),
        .err_flag     (err_flag),
        .state_ab     (state_ab)
`ifdef QUAD_INDEX_EN
        ,
        .z_in         (1'b0),
        .index        (index_w)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Called right after a negedge; drives {A,B} and optionally queues the
    // hand-computed event it should cause.
    task automatic drive(input logic [1:0] ab, input bit push, input bit kind,
                         input bit dir, input int hold);
        ev_t ev;
        a_in = ab[1];
        b_in = ab[0];
        if (push) begin
            ev.kind = kind;
            ev.dir  = dir;
            ev.ab   = ab;
            ev.due  = cyc + LAT;
            sb_q.push_back(ev);
        end
        repeat (hold) @(negedge clk);
    endtask

    always @(negedge clk) begin
        ev_t ev;
        if (step || err) begin
            $display("txn %s ab=%b dir=%b err_flag=%b cyc=%0d",
                     err ? "err " : "step", state_ab, count_up_down, err_flag, cyc);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: step=%b err=%b, want none (cyc %0d)", step, err, cyc);
            end else begin
                ev = sb_q.pop_front();
                check("ev_kind", {31'd0, err}, {31'd0, ev.kind});
                check("ev_step", {31'd0, step}, {31'd0, ~ev.kind});
                check("ev_dir", {31'd0, count_up_down}, {31'd0, ev.dir});
                check("ev_state_ab", {30'd0, state_ab}, {30'd0, ev.ab});
                check("ev_latency", cyc, ev.due);
                if (ev.kind) check("ev_err_flag", {31'd0, err_flag}, 32'd1);
            end
        end
        if (sb_q.size() > 0 && cyc > sb_q[0].due) begin
            ev = sb_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: no pulse by cyc %0d, want ab=%b due %0d", cyc, ev.ab, ev.due);
        end
    end

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        a_in    = 1'b1;
        b_in    = 1'b1;
        err_clr = 1'b0;

        // Reset with A=B=1, then priming loads 11 on the second edge.
        repeat (3) @(negedge clk);
        check("rst_step", {31'd0, step}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_err_flag", {31'd0, err_flag}, 32'd0);
        check("rst_dir", {31'd0, count_up_down}, 32'd1);
        check("rst_state_ab", {30'd0, state_ab}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("prime1_ab", {30'd0, state_ab}, 32'd0);
        @(negedge clk);
        check("prime2_ab", {30'd0, state_ab}, 32'd3);
        repeat (10) @(negedge clk);
        check("prime_hold_ab", {30'd0, state_ab}, 32'd3);
        check("prime_err_flag", {31'd0, err_flag}, 32'd0);

        // Re-reset with A=B=0 to start rotations from 00.
        a_in  = 1'b0;
        b_in  = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("start_ab", {30'd0, state_ab}, 32'd0);

        // Forward rotation.
        drive(2'b01, 1, 0, 1, 10);
        drive(2'b11, 1, 0, 1, 10);
        drive(2'b10, 1, 0, 1, 10);
        drive(2'b00, 1, 0, 1, 10);

        // Reverse then forward; direction holds between the pulses.
        drive(2'b10, 1, 0, 0, 10);
        check("dir_hold", {31'd0, count_up_down}, 32'd0);
        drive(2'b00, 1, 0, 1, 10);

        // Two-cycle glitch on A is swallowed.
        a_in = 1'b1;
        repeat (2) @(negedge clk);
        a_in = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_ab", {30'd0, state_ab}, 32'd0);
        check("glitch_err_flag", {31'd0, err_flag}, 32'd0);

        // Illegal 00->11, then clear the sticky flag.
        drive(2'b11, 1, 1, 1, 10);
        check("illegal_err_flag", {31'd0, err_flag}, 32'd1);
        check("illegal_ab", {30'd0, state_ab}, 32'd3);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("clr_err_flag", {31'd0, err_flag}, 32'd0);

        // Illegal 11->00 with err_clr coincident with the err pulse.
        drive(2'b00, 1, 1, 1, LAT);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("set_wins_err_flag", {31'd0, err_flag}, 32'd1);
        repeat (3) @(negedge clk);

        // Reverse step, then reset in the middle of the next filter count.
        drive(2'b10, 1, 0, 0, 10);
        drive(2'b11, 0, 0, 0, 3);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_step", {31'd0, step}, 32'd0);
        check("mid_rst_err", {31'd0, err}, 32'd0);
        check("mid_rst_err_flag", {31'd0, err_flag}, 32'd0);
        check("mid_rst_dir", {31'd0, count_up_down}, 32'd1);
        check("mid_rst_ab", {30'd0, state_ab}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("reprime1_ab", {30'd0, state_ab}, 32'd0);
        @(negedge clk);
        check("reprime2_ab", {30'd0, state_ab}, 32'd3);
        repeat (5) @(negedge clk);

        // Normal operation resumes from 11.
        drive(2'b10, 1, 0, 1, 10);
        drive(2'b00, 1, 0, 1, 10);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, want finish by 100000");
        $fatal(1);
    end

endmodule
